uart_receiver: RTL
==================

Name: uart_receiver

Overview:
- Serial-to-parallel UART receiver: the far end of the existing transmitter link.
- Frame format: 8N1 by default, idle-high, LSB first. Each bit is sampled once, at mid-bit, using a cycle counter.
- Sits between the external RX pin and the SoC peripheral bus logic. It presents each received byte with a one-cycle valid strobe.
- Default timing matches the transmitter: 100 MHz clk, 9600 baud.

Parameters:
- DATAWIDTH, 8, data bits per frame.
- CLKS_PER_BIT, 10416, clk cycles per bit; must be at least 4.

Ports:
- clk  input  1  system clock; all logic is on the rising edge.
- i_reset  input  1  asynchronous, active-high reset.
- i_rx_data  input  1  serial line, asynchronous to clk, idle high.
- o_data  output  DATAWIDTH  last correctly received word; holds until the next good frame.
- o_valid  output  1  one-cycle pulse when o_data is updated.
- o_frame_err  output  1  one-cycle pulse when the stop bit is sampled low.
- o_busy  output  1  high whenever the FSM is not in IDLE.

Behaviour:
- Reset is asynchronous and active-high.
  - Reset values: o_data=0, o_valid=0, o_frame_err=0, o_busy=0.
  - FSM goes to IDLE; bit counter and cycle counter clear.
  - Both synchronizer flops reset to 1.
  - Reset asserted mid-frame aborts the frame with no strobe.
- Input path: i_rx_data passes through a 2-FF synchronizer to give rx_s. The FSM uses rx_s only, so there are 2 cycles of input latency.
- cnt is a cycle counter of width $clog2(CLKS_PER_BIT). bit_idx is a bit counter of width $clog2(DATAWIDTH+1).
- IDLE
  - Entry condition: rx_s==0 → go to START, cnt=0.
- START
  - When cnt==CLKS_PER_BIT/2-1 (integer division), sample rx_s:
    - rx_s==0 → go to DATA, cnt=0, bit_idx=0.
    - rx_s==1 → the start was a glitch; go to IDLE with no strobe.
  - Otherwise cnt increments.
- DATA
  - When cnt==CLKS_PER_BIT-1, shift rx_s into the MSB of the shift register (shift right, LSB first) and reset cnt.
  - After bit DATAWIDTH-1 is shifted in, go to STOP. The feature below adds a PARITY state between DATA and STOP.
- STOP
  - When cnt==CLKS_PER_BIT-1, sample rx_s:
    - rx_s==1 → o_data = shift register, o_valid=1 for one cycle, go to IDLE.
    - rx_s==0 → o_frame_err=1 for one cycle, o_data unchanged, go to BREAK.
- BREAK
  - Wait for rx_s==1, then go to IDLE. This stops a held-low line (break condition) from being decoded as repeated 0x00 frames.
- Timing and strobe rules:
  - The strobe occurs at the middle of the stop bit: about 9.5×CLKS_PER_BIT + 2 cycles after the falling edge of the start bit.
  - The receiver is ready for the next start bit immediately after the strobe cycle. Back-to-back frames must be received with no gap.
  - o_valid and o_frame_err are never high in the same cycle.
- i_rx_data may change at any time relative to clk. Metastability is contained in the first synchronizer flop only.

Optional Feature:
- Macro: UART_RX_PARITY_EN
- Defined:
  - Parameter PARITY_ODD (default 0) is added: 0 selects even parity, 1 selects odd.
  - A PARITY state is inserted after DATA. It samples one parity bit after CLKS_PER_BIT cycles, then goes to STOP.
  - Output o_parity_err (1 bit, reset 0) is added. It pulses together with o_valid when the received parity does not match the computed parity (XOR of the data bits, inverted if PARITY_ODD=1).
  - o_data still updates and o_valid still pulses on a parity error, because parity errors are reported separately.
- Undefined: there is no PARITY state and no o_parity_err port; frames are 8N1.

Test Plan:
- Reset behaviour: assert i_reset in the middle of receiving 0xA5 → all outputs are 0 immediately, with no strobe. After release, 0x3C sent cleanly → o_valid once, o_data=0x3C.
- Default timing: CLKS_PER_BIT=10416, 10 ns clk, send 0x33 → o_valid pulses about 98,960 cycles after the start edge, o_data=0x33, o_frame_err stays 0.
- Back-to-back frames: CLKS_PER_BIT=16, send 0xAA, 0x0F, 0xFF with no idle gap → three o_valid pulses with o_data 0xAA, 0x0F, 0xFF in order.
- Glitch rejection: a low pulse of CLKS_PER_BIT/2-2 cycles on an idle line → FSM returns to IDLE, no o_valid, no o_frame_err.
- Framing error and break: send 0x55 with the stop bit driven 0 and the line then held low for 3 frame times → exactly one o_frame_err pulse, o_data keeps its previous value, no o_valid. After the line rises, 0x81 → o_valid, o_data=0x81.
- With UART_RX_PARITY_EN and PARITY_ODD=0: send 0x07 with parity bit 1 → o_valid, o_parity_err=0. Send 0x07 with parity bit 0 → o_valid and o_parity_err pulse together.

Source files
------------

// File: rtl/uart_receiver.sv
// uart_receiver: mid-bit sampling UART receiver (8N1 default, idle-high, LSB first)
// Ports:
//   clk          system clock, rising edge
//   i_reset      asynchronous active-high reset
//   i_rx_data    serial line, asynchronous to clk, idle high
//   o_data       last correctly framed word, held until the next good frame
//   o_valid      one-cycle pulse when o_data updates
//   o_frame_err  one-cycle pulse when the stop bit is sampled low
//   o_busy       high whenever the FSM is not idle
//   o_parity_err (UART_RX_PARITY_EN only) pulses with o_valid on a parity mismatch
// Optional parity: define UART_RX_PARITY_EN to add a parity bit (PARITY_ODD selects odd).
module uart_receiver #(
    parameter int DATAWIDTH    = 8,
    parameter int CLKS_PER_BIT = 10416
`ifdef UART_RX_PARITY_EN
    , parameter bit PARITY_ODD = 1'b0
`endif
) (
    input  logic                 clk,
    input  logic                 i_reset,
    input  logic                 i_rx_data,
    output logic [DATAWIDTH-1:0] o_data,
    output logic                 o_valid,
    output logic                 o_frame_err,
    output logic                 o_busy
`ifdef UART_RX_PARITY_EN
    , output logic               o_parity_err
`endif
);
    localparam int CW = $clog2(CLKS_PER_BIT);
    localparam int BW = $clog2(DATAWIDTH + 1);
    localparam logic [CW-1:0] HALF = CW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CW-1:0] FULL = CW'(CLKS_PER_BIT - 1);
    localparam logic [BW-1:0] LAST = BW'(DATAWIDTH - 1);

`ifdef UART_RX_PARITY_EN
    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP, BREAK} state_t;
    logic par_bit;
`else
    typedef enum logic [2:0] {IDLE, START, DATA, STOP, BREAK} state_t;
`endif

    state_t                 state;
    logic [CW-1:0]          cnt;
    logic [BW-1:0]          bit_idx;
    logic [DATAWIDTH-1:0]   shreg;
    logic                   sync1, rx_s;

    // Both flops reset to the idle level so a reset never looks like a start bit.
    always_ff @(posedge clk or posedge i_reset) begin
        if (i_reset) begin
            sync1 <= 1'b1;
            rx_s  <= 1'b1;
        end else begin
            sync1 <= i_rx_data;
            rx_s  <= sync1;
        end
    end

    always_ff @(posedge clk or posedge i_reset) begin
        if (i_reset) begin
            state       <= IDLE;
            cnt         <= '0;
            bit_idx     <= '0;
            shreg       <= '0;
            o_data      <= '0;
            o_valid     <= 1'b0;
            o_frame_err <= 1'b0;
            o_busy      <= 1'b0;
`ifdef UART_RX_PARITY_EN
            par_bit      <= 1'b0;
            o_parity_err <= 1'b0;
`endif
        end else begin
            o_valid     <= 1'b0;
            o_frame_err <= 1'b0;
`ifdef UART_RX_PARITY_EN
            o_parity_err <= 1'b0;
`endif
            case (state)
                IDLE: if (!rx_s) begin
                    state  <= START;
                    cnt    <= '0;
                    o_busy <= 1'b1;
                end
                // A start bit that is high again at mid-bit is treated as a glitch.
                START: if (cnt == HALF) begin
                    cnt     <= '0;
                    bit_idx <= '0;
                    state   <= rx_s ? IDLE : DATA;
                    o_busy  <= !rx_s;
                end else cnt <= cnt + 1'b1;
                DATA: if (cnt == FULL) begin
                    cnt     <= '0;
                    shreg   <= {rx_s, shreg[DATAWIDTH-1:1]};
                    bit_idx <= bit_idx + 1'b1;
`ifdef UART_RX_PARITY_EN
                    if (bit_idx == LAST) state <= PARITY;
`else
                    if (bit_idx == LAST) state <= STOP;
`endif
                end else cnt <= cnt + 1'b1;
`ifdef UART_RX_PARITY_EN
                PARITY: if (cnt == FULL) begin
                    cnt     <= '0;
                    par_bit <= rx_s;
                    state   <= STOP;
                end else cnt <= cnt + 1'b1;
`endif
                STOP: if (cnt == FULL) begin
                    cnt <= '0;
                    if (rx_s) begin
                        o_data  <= shreg;
                        o_valid <= 1'b1;
                        state   <= IDLE;
                        o_busy  <= 1'b0;
`ifdef UART_RX_PARITY_EN
                        o_parity_err <= (^shreg ^ PARITY_ODD) != par_bit;
`endif
                    end else begin
                        o_frame_err <= 1'b1;
                        state       <= BREAK;
                    end
                end else cnt <= cnt + 1'b1;
                // Held-low line: wait for idle rather than decoding 0x00 frames.
                BREAK: if (rx_s) begin
                    state  <= IDLE;
                    o_busy <= 1'b0;
                end
                default: begin
                    state  <= IDLE;
                    o_busy <= 1'b0;
                end
            endcase
        end
    end
endmodule
